// File: rtl/run_controller_pkg.sv
// Shared definitions for the run/step/halt controller: sequencer control
// addresses, controller state encodings and the 3-phase instruction cycle.
package run_controller_pkg;

   localparam logic [3:0] CA_FETCH = 4'b0000;
   localparam logic [3:0] CA_HLT   = 4'b1010;

   typedef enum logic [2:0] {
      ST_RESET_HOLD = 3'd0,
      ST_STOPPED    = 3'd1,
      ST_RUN        = 3'd2,
      ST_STEP       = 3'd3,
      ST_HALTED     = 3'd4
   } run_state_t;

   localparam logic [1:0] PH_FETCH  = 2'd0;
   localparam logic [1:0] PH_DECODE = 2'd1;
   localparam logic [1:0] PH_EXEC   = 2'd2;

   // Phase follows fetch -> decode -> execute and wraps back to fetch.
   function automatic logic [1:0] next_phase(input logic [1:0] ph);
      return (ph == PH_EXEC) ? PH_FETCH : ph + 2'd1;
   endfunction

endpackage

// File: rtl/run_controller.sv
// Run/step/halt controller: gates the sequencer/datapath with one clock enable,
// owns the sequencer reset, handles HLT, breakpoints, stepping and retire count.
module run_controller
   import run_controller_pkg::*;
#(
   parameter int PC_WIDTH     = 8,
   parameter int COUNT_WIDTH  = 16,
   parameter int RESET_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run_req,
   input  logic                   step_req,
   input  logic                   halt_req,
   input  logic                   clear_req,
   input  logic [3:0]             control_address,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic                   bp_enable,
   input  logic [PC_WIDTH-1:0]    bp_addr,
   output logic                   cpu_en,
   output logic                   reset_sequencer,
   output logic [2:0]             state,
   output logic                   halted,
   output logic                   seq_error,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);

   run_state_t             state_r, state_s;
   logic [1:0]             phase_r, phase_s;
   logic [HOLD_W-1:0]      hold_r, hold_s;
   logic [COUNT_WIDTH-1:0] count_r, count_s;
   logic                   seq_error_r, seq_error_s;
   logic                   skip_r, skip_s;
   logic                   pend_r, pend_s;

   logic bp_hit_s, cpu_en_s, clear_s, sync_err_s, retire_s, hlt_s;

   // Per-cycle events; a clear suppresses every other event in its cycle.
   assign bp_hit_s   = (state_r == ST_RUN) && (phase_r == PH_FETCH) && bp_enable
                       && (pc == bp_addr) && !skip_r;
   assign cpu_en_s   = ((state_r == ST_RUN) && !bp_hit_s) || (state_r == ST_STEP);
   assign clear_s    = clear_req && (state_r != ST_RESET_HOLD);
   assign sync_err_s = cpu_en_s && (phase_r == PH_FETCH) && (control_address != CA_FETCH) && !clear_s;
   assign retire_s   = cpu_en_s && (phase_r == PH_EXEC) && !clear_s;
   assign hlt_s      = retire_s && (control_address == CA_HLT);

   // Next-state, phase, counters and flags.
   always_comb begin
      state_s     = state_r;
      phase_s     = clear_s ? PH_FETCH : (cpu_en_s ? next_phase(phase_r) : phase_r);
      hold_s      = (state_r == ST_RESET_HOLD) ? hold_r - HOLD_W'(1) : HOLD_INIT;
      count_s     = retire_s ? count_r + COUNT_WIDTH'(1) : count_r;
      seq_error_s = seq_error_r | sync_err_s;
      skip_s      = retire_s ? 1'b0 : skip_r;
      case (state_r)
         ST_RESET_HOLD: begin
            state_s = (hold_r == {HOLD_W{1'b0}}) ? ST_STOPPED : ST_RESET_HOLD;
         end
         ST_STOPPED: begin
            if (clear_s) begin
               state_s = ST_RESET_HOLD;
            end else if (step_req) begin
               state_s = ST_STEP;
               skip_s  = 1'b1;
            end else if (run_req) begin
               state_s = ST_RUN;
               skip_s  = 1'b1;
            end else begin
               state_s = ST_STOPPED;
            end
         end
         ST_RUN: begin
            if (clear_s) begin
               state_s = ST_RESET_HOLD;
            end else if (sync_err_s || hlt_s) begin
               state_s = ST_HALTED;
            end else if (bp_hit_s || (retire_s && (pend_r || halt_req))) begin
               state_s = ST_STOPPED;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_STEP: begin
            if (clear_s) begin
               state_s = ST_RESET_HOLD;
            end else if (sync_err_s || hlt_s) begin
               state_s = ST_HALTED;
            end else if (retire_s) begin
               state_s = ST_STOPPED;
            end else begin
               state_s = ST_STEP;
            end
         end
         ST_HALTED: begin
            state_s = clear_s ? ST_RESET_HOLD : ST_HALTED;
         end
         default: begin
            state_s = ST_RESET_HOLD;
         end
      endcase
      // A stop request survives only while the controller keeps running.
      pend_s = ((state_r == ST_RUN) && (state_s == ST_RUN)) ? (pend_r | halt_req) : 1'b0;
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_RESET_HOLD;
         phase_r     <= PH_FETCH;
         hold_r      <= HOLD_INIT;
         count_r     <= {COUNT_WIDTH{1'b0}};
         seq_error_r <= 1'b0;
         skip_r      <= 1'b0;
         pend_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         phase_r     <= phase_s;
         hold_r      <= hold_s;
         count_r     <= count_s;
         seq_error_r <= seq_error_s;
         skip_r      <= skip_s;
         pend_r      <= pend_s;
      end
   end

   assign cpu_en          = cpu_en_s;
   assign reset_sequencer = (state_r == ST_RESET_HOLD);
   assign state           = state_r;
   assign halted          = (state_r == ST_HALTED);
   assign seq_error       = seq_error_r;
   assign instr_count     = count_r;

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Run/step/halt controller for the CPU core. It gates the sequencer and datapath through a single clock enable and owns the sequencer's reset pulse. It detects HLT execution, applies a PC breakpoint, supports single-instruction stepping and counts retired instructions. It sits between the debug/front-panel request inputs and the sequencer/datapath enable and reset inputs.

Parameters:
PC_WIDTH, 8, width of program counter and breakpoint address
COUNT_WIDTH, 16, width of retired-instruction counter
RESET_CYCLES, 2, cycles reset_sequencer is held high on entry to RESET_HOLD (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high controller reset
run_req  input  1  pulse: start free-running execution
step_req  input  1  pulse: execute exactly one instruction
halt_req  input  1  pulse: stop at next instruction boundary
clear_req  input  1  pulse: resynchronise sequencer, counters kept
control_address  input  4  current sequencer control address
pc  input  PC_WIDTH  current program counter
bp_enable  input  1  breakpoint enable
bp_addr  input  PC_WIDTH  breakpoint address
cpu_en  output  1  clock enable to sequencer and datapath
reset_sequencer  output  1  reset to sequencer, active-high
state  output  3  current state encoding
halted  output  1  high in HALTED
seq_error  output  1  sticky: sequencer out of sync
instr_count  output  COUNT_WIDTH  retired instructions, wraps

Behaviour:
- Reset: state=RESET_HOLD, hold counter=RESET_CYCLES-1, phase=0, instr_count=0, seq_error=0, skip_bp=0.
- States: RESET_HOLD, STOPPED, RUN, STEP, HALTED.
- reset_sequencer=1 iff state==RESET_HOLD. After RESET_CYCLES cycles -> STOPPED, phase=0.
- cpu_en = (state==RUN && !bp_hit) || state==STEP. Combinational.
- phase: 0..2, advances only on cpu_en cycles and wraps 2->0. It mirrors the 3-cycle sequencer (fetch, decode, execute). Boundary means phase==0.
- Retire: a cpu_en cycle with phase==2 increments instr_count (wraps at 2^COUNT_WIDTH).
- Sync check: on a cpu_en cycle with phase==0 and control_address!=CA_FETCH (4'b0000), set seq_error and go HALTED next cycle. seq_error clears only on reset.
- HLT: on a cpu_en cycle with phase==2 and control_address==CA_HLT (4'b1010), the instruction retires and the state goes HALTED. cpu_en is low from the next cycle.
- bp_hit = state==RUN && phase==0 && bp_enable && pc==bp_addr && !skip_bp. On bp_hit, cpu_en=0 that cycle and the state goes STOPPED. The instruction at bp_addr is not executed.
- skip_bp: set on any transition STOPPED->RUN or STOPPED->STEP; cleared on the first retire after that. Resuming from a breakpoint therefore executes that instruction once.
- STOPPED: step_req -> STEP; else run_req -> RUN. halt_req is ignored.
- RUN: halt_req latches a pending-stop flag. At the next retire (phase==2 cpu_en cycle) the state goes STOPPED, unless HLT or a sync error selects HALTED. step_req and run_req are ignored.
- STEP: runs exactly one instruction (3 cpu_en cycles), then STOPPED (or HALTED on HLT or sync error). All requests except clear_req are ignored.
- HALTED: only clear_req or reset leaves it. run_req and step_req are ignored.
- clear_req (any state except RESET_HOLD): -> RESET_HOLD, phase=0, pending stop cleared. Takes priority over every other request and event in the same cycle. instr_count is kept.
- Same-cycle priority: reset > clear_req > sync error > HLT > bp_hit > halt/stop > step_req > run_req.
- Requests are single-cycle pulses and are not queued, except halt_req in RUN.

Decomposition:
- Shared package/header (alongside the opcode definitions): CA_FETCH=4'b0000, CA_HLT=4'b1010, and state encodings RESET_HOLD=0, STOPPED=1, RUN=2, STEP=3, HALTED=4.
- No sub-module required. The phase counter and FSM stay in one module.

Test Plan:
- Reset, hold 2 cycles -> reset_sequencer=1 for exactly RESET_CYCLES=2 cycles after release, then state=STOPPED, cpu_en=0, instr_count=0.
- step_req with a model sequencer (ADD at pc=0) -> cpu_en high exactly 3 cycles, instr_count=1, state=STOPPED, phase=0.
- run_req, program ADD,ADD,HLT -> cpu_en high 9 cycles, then halted=1, instr_count=3; a later run_req leaves cpu_en=0.
- bp_enable=1, bp_addr=2, run_req -> stops with pc=2, instr_count=2, cpu_en=0. A second run_req executes pc=2 without re-trigger.
- Force control_address=4'b0011 at phase 0 -> seq_error=1, state=HALTED; clear_req -> RESET_HOLD, then STOPPED, seq_error still 1.
- halt_req during phase 1 in RUN -> stops after that instruction retires (phase 2), state=STOPPED. clear_req and run_req in the same cycle -> RESET_HOLD wins.
